uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 67 ++++++
 rtl/uart_fifo.sv | 63 ++++++
 rtl/uart_tx_fifo.sv | 213 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity-mode and data-length encodings,
// plus small helpers for frame setup. Reused by the transmitter and receiver.
// Defining UART_TX_BREAK_EN adds the BREAK and MARK states.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
`ifdef UART_TX_BREAK_EN
    ,
    ST_BREAK  = 3'd6,
    ST_MARK   = 3'd7
`endif
  } uart_state_e;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'b00,
    PARITY_EVEN = 2'b01,
    PARITY_ODD  = 2'b10,
    PARITY_MARK = 2'b11
  } parity_mode_e;

  typedef enum logic [1:0] {
    LEN_5 = 2'b00,
    LEN_6 = 2'b01,
    LEN_7 = 2'b10,
    LEN_8 = 2'b11
  } data_len_e;

  // Index of the last data bit sent for a given length (4 for 5 bits ... 7 for 8 bits).
  function automatic logic [2:0] last_bit_index(input data_len_e len);
    return {1'b0, len} + 3'd4;
  endfunction

  // Mask keeping only the data bits that belong to the selected length.
  function automatic logic [7:0] data_mask(input data_len_e len);
    logic [7:0] mask;
    case (len)
      LEN_5:   mask = 8'h1F;
      LEN_6:   mask = 8'h3F;
      LEN_7:   mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // Parity bit over the selected data bits only; mark parity is always 1.
  function automatic logic parity_bit(input logic [7:0] data,
                                      input data_len_e len,
                                      input parity_mode_e mode);
    logic [7:0] masked;
    logic       result;
    masked = data & data_mask(len);
    case (mode)
      PARITY_EVEN: result = ^masked;
      PARITY_ODD:  result = ~^masked;
      PARITY_MARK: result = 1'b1;
      default:     result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Single-clock synchronous FIFO with registered full, level and overflow.
// First-word fall-through: pop_data shows the head entry whenever not empty.
// Pushes while full are dropped and flagged by a one-cycle overflow pulse.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [AW:0]      level_next;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (level == '0);
  assign pop_data = mem[rd_ptr];

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_next = level + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointers, occupancy, full flag and overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level    <= level_next;
      full     <= (level_next == (AW+1)'(DEPTH));
      overflow <= push && full;
    end
  end

  // Storage array; needs no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a transmit FIFO.
// Frame: start bit, 5..8 data bits LSB first, optional parity, one or two stop bits.
// Frame format and divider are captured when a byte is popped and held for that frame.
// Define UART_TX_BREAK_EN to add the break_i input and break generation.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        write_i,
  input  logic [7:0]                  data_i,
  input  logic [1:0]                  data_bits_i,
  input  logic [1:0]                  parity_mode_i,
  input  logic                        two_stop_bits_i,
  input  logic [DIV_WIDTH-1:0]        clock_divider_i,
`ifdef UART_TX_BREAK_EN
  input  logic                        break_i,
`endif
  output logic                        serial_o,
  output logic                        busy_o,
  output logic                        full_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        overflow_o
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  uart_state_e          state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [DIV_WIDTH-1:0] div_q, div_n;
  logic [7:0]           shreg, shreg_n;
  logic [2:0]           idx, idx_n;
  logic [2:0]           last_idx, last_n;
  logic                 par_en, par_en_n;
  logic                 par_bit, par_n;
  logic                 stop2, stop2_n;
  logic                 serial_q, serial_n;

  logic [DIV_WIDTH-1:0] div_eff;
  logic                 bit_done;
  logic                 decide;
  logic                 pop;
  logic [7:0]           fifo_data;
  logic                 fifo_empty;
  data_len_e            len_sel;
  parity_mode_e         mode_sel;

  assign div_eff  = (clock_divider_i == '0) ? ONE : clock_divider_i;
  assign bit_done = (cnt == '0);
  assign len_sel  = data_len_e'(data_bits_i);
  assign mode_sel = parity_mode_e'(parity_mode_i);
  assign serial_o = serial_q;
  assign busy_o   = (state != ST_IDLE) || !fifo_empty;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clock_i),
    .rst       (reset_i),
    .push      (write_i),
    .push_data (data_i),
    .pop       (pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .full      (full_o),
    .level     (level_o),
    .overflow  (overflow_o)
  );

  // State and datapath registers; reset aborts any frame and idles the line high.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      div_q    <= ONE;
      shreg    <= '0;
      idx      <= '0;
      last_idx <= 3'd7;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop2    <= 1'b0;
      serial_q <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      div_q    <= div_n;
      shreg    <= shreg_n;
      idx      <= idx_n;
      last_idx <= last_n;
      par_en   <= par_en_n;
      par_bit  <= par_n;
      stop2    <= stop2_n;
      serial_q <= serial_n;
    end
  end

  // Next-state logic: bit sequencing, and the idle/frame-end decision to pop or stop.
  always_comb begin
    state_n  = state;
    cnt_n    = bit_done ? cnt : cnt - ONE;
    div_n    = div_q;
    shreg_n  = shreg;
    idx_n    = idx;
    last_n   = last_idx;
    par_en_n = par_en;
    par_n    = par_bit;
    stop2_n  = stop2;
    serial_n = serial_q;
    pop      = 1'b0;
    decide   = 1'b0;

    case (state)
      ST_IDLE: begin
        decide = 1'b1;
      end
      ST_START: begin
        if (bit_done) begin
          state_n  = ST_DATA;
          serial_n = shreg[0];
          cnt_n    = div_q - ONE;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_n = div_q - ONE;
          if (idx == last_idx) begin
            if (par_en) begin
              state_n  = ST_PARITY;
              serial_n = par_bit;
            end else begin
              state_n  = ST_STOP1;
              serial_n = 1'b1;
            end
          end else begin
            idx_n    = idx + 3'd1;
            shreg_n  = {1'b0, shreg[7:1]};
            serial_n = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_n  = ST_STOP1;
          serial_n = 1'b1;
          cnt_n    = div_q - ONE;
        end
      end
      ST_STOP1: begin
        if (bit_done) begin
          if (stop2) begin
            state_n  = ST_STOP2;
            serial_n = 1'b1;
            cnt_n    = div_q - ONE;
          end else begin
            decide = 1'b1;
          end
        end
      end
      ST_STOP2: begin
        if (bit_done) decide = 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (!break_i) begin
          state_n  = ST_MARK;
          serial_n = 1'b1;
          cnt_n    = div_eff - ONE;
        end
      end
      ST_MARK: begin
        if (bit_done) begin
          state_n  = ST_IDLE;
          serial_n = 1'b1;
        end
      end
`endif
      default: begin
        state_n  = ST_IDLE;
        serial_n = 1'b1;
      end
    endcase

    if (decide) begin
`ifdef UART_TX_BREAK_EN
      if (break_i) begin
        state_n  = ST_BREAK;
        serial_n = 1'b0;
      end else
`endif
      if (!fifo_empty) begin
        pop      = 1'b1;
        state_n  = ST_START;
        serial_n = 1'b0;
        cnt_n    = div_eff - ONE;
        div_n    = div_eff;
        shreg_n  = fifo_data;
        idx_n    = '0;
        last_n   = last_bit_index(len_sel);
        par_en_n = (mode_sel != PARITY_NONE);
        par_n    = parity_bit(fifo_data, len_sel, mode_sel);
        stop2_n  = two_stop_bits_i;
      end else begin
        state_n  = ST_IDLE;
        serial_n = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (FIFO_DEPTH=4).
// The reference model keeps a byte queue for the FIFO and a queue of expected
// line levels, one per clock, built from the frame rules when a byte is popped.
// Define UART_TX_BREAK_EN to also exercise break generation.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          write_i;
  logic [7:0]    data_i;
  logic [1:0]    data_bits_i;
  logic [1:0]    parity_mode_i;
  logic          two_stop_bits_i;
  logic [DW-1:0] clock_divider_i;
`ifdef UART_TX_BREAK_EN
  logic          break_i = 1'b0;
`endif
  logic          serial_o;
  logic          busy_o;
  logic          full_o;
  logic [LW-1:0] level_o;
  logic          overflow_o;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int ovf_seen = 0;

  logic [7:0] model_fifo[$];
  logic       exp_q[$];

  uart_tx_fifo #(
    .FIFO_DEPTH (DEPTH),
    .DIV_WIDTH  (DW)
  ) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .write_i         (write_i),
    .data_i          (data_i),
    .data_bits_i     (data_bits_i),
    .parity_mode_i   (parity_mode_i),
    .two_stop_bits_i (two_stop_bits_i),
    .clock_divider_i (clock_divider_i),
`ifdef UART_TX_BREAK_EN
    .break_i         (break_i),
`endif
    .serial_o        (serial_o),
    .busy_o          (busy_o),
    .full_o          (full_o),
    .level_o         (level_o),
    .overflow_o      (overflow_o)
  );

  always #5 clock_i = ~clock_i;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  // Append the line levels of one frame, using the format inputs present at the pop.
  function automatic void add_frame(input logic [7:0] d);
    int   nb;
    int   div;
    logic masked_par;
    logic bits[$];
    nb  = 5 + int'(data_bits_i);
    div = (clock_divider_i == 0) ? 1 : int'(clock_divider_i);
    masked_par = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(d[i]);
      masked_par = masked_par ^ d[i];
    end
    case (parity_mode_i)
      2'b01: bits.push_back(masked_par);
      2'b10: bits.push_back(~masked_par);
      2'b11: bits.push_back(1'b1);
      default: ;
    endcase
    bits.push_back(1'b1);
    if (two_stop_bits_i) bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i++)
      for (int r = 0; r < div; r++) exp_q.push_back(bits[i]);
  endfunction

  // Drive one clock of stimulus, advance the model, then check every output.
  task automatic applyStimulus(input logic wr, input logic [7:0] d);
    logic pop_now;
    logic accept;
    logic ovf_exp;
    logic ser_exp;
    logic in_frame;
    write_i = wr;
    data_i  = d;
    pop_now = (exp_q.size() == 0) && (model_fifo.size() > 0);
    accept  = wr && (model_fifo.size() < DEPTH);
    ovf_exp = wr && !accept;
    if (pop_now) add_frame(model_fifo.pop_front());
    if (accept) model_fifo.push_back(d);
    @(posedge clock_i);
    #1;
    cycle++;
    if (exp_q.size() > 0) begin
      ser_exp  = exp_q.pop_front();
      in_frame = 1'b1;
    end else begin
      ser_exp  = 1'b1;
      in_frame = 1'b0;
    end
    checkOutput("serial", 32'(serial_o), 32'(ser_exp));
    checkOutput("busy", 32'(busy_o), 32'(in_frame || (model_fifo.size() > 0)));
    checkOutput("level", 32'(level_o), 32'(model_fifo.size()));
    checkOutput("full", 32'(full_o), 32'(model_fifo.size() == DEPTH));
    checkOutput("overflow", 32'(overflow_o), 32'(ovf_exp));
    if (overflow_o) ovf_seen++;
    write_i = 1'b0;
  endtask

  // Run idle cycles until the model has nothing left, bounded by a cycle budget.
  task automatic drainUntilIdle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || model_fifo.size() > 0) && n < budget) begin
      applyStimulus(1'b0, 8'h00);
      n++;
    end
    checkOutput("drain_in_budget", 32'(n < budget), 32'd1);
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
  endtask

  task automatic setFormat(input logic [1:0] bits, input logic [1:0] par,
                           input logic stop2, input int div);
    data_bits_i     = bits;
    parity_mode_i   = par;
    two_stop_bits_i = stop2;
    clock_divider_i = DW'(div);
  endtask

  initial begin
    logic [7:0] d;
    reset_i = 1'b1;
    write_i = 1'b0;
    data_i  = 8'h00;
    setFormat(2'b11, 2'b00, 1'b0, 1);

    $display("[TB] reset state");
    #12;
    checkOutput("rst_serial", 32'(serial_o), 32'd1);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_full", 32'(full_o), 32'd0);
    checkOutput("rst_level", 32'(level_o), 32'd0);
    checkOutput("rst_overflow", 32'(overflow_o), 32'd0);
    @(negedge clock_i);
    reset_i = 1'b0;

    $display("[TB] divider 1, 8N1, byte 0x55");
    setFormat(2'b11, 2'b00, 1'b0, 1);
    applyStimulus(1'b1, 8'h55);
    drainUntilIdle(200);

    $display("[TB] divider 4, 7E2, byte 0x83");
    setFormat(2'b10, 2'b01, 1'b1, 4);
    applyStimulus(1'b1, 8'h83);
    drainUntilIdle(200);

    $display("[TB] divider 1, 8N1, three bytes back to back");
    setFormat(2'b11, 2'b00, 1'b0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'($urandom));
    drainUntilIdle(200);

    $display("[TB] fill and overflow while a frame is in progress");
    setFormat(2'b11, 2'b00, 1'b0, 3);
    applyStimulus(1'b1, 8'($urandom));
    applyStimulus(1'b0, 8'h00);
    ovf_seen = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'($urandom));
      if (i == 3) checkOutput("full_after_4th", 32'(full_o), 32'd1);
    end
    checkOutput("overflow_pulses", 32'(ovf_seen), 32'd2);
    drainUntilIdle(1000);

    $display("[TB] randomized writes with format changing every cycle");
    for (int i = 0; i < 300; i++) begin
      setFormat(2'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 3) == 0), 8'($urandom));
    end
    drainUntilIdle(3000);

    $display("[TB] divider 0 behaves as 1");
    setFormat(2'b00, 2'b11, 1'b0, 0);
    applyStimulus(1'b1, 8'($urandom));
    drainUntilIdle(200);

    $display("[TB] reset during data bit 3");
    setFormat(2'b11, 2'b00, 1'b0, 2);
    d = 8'($urandom) & 8'hF7;
    applyStimulus(1'b1, d);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 8'h00);
    checkOutput("bit3_low", 32'(serial_o), 32'd0);
    #2;
    reset_i = 1'b1;
    #1;
    checkOutput("midrst_serial", 32'(serial_o), 32'd1);
    checkOutput("midrst_busy", 32'(busy_o), 32'd0);
    checkOutput("midrst_level", 32'(level_o), 32'd0);
    exp_q.delete();
    model_fifo.delete();
    @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 8'h00);

`ifdef UART_TX_BREAK_EN
    $display("[TB] break for 20 clocks from idle");
    setFormat(2'b11, 2'b00, 1'b0, 3);
    break_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock_i);
      #1;
      cycle++;
      checkOutput("break_serial", 32'(serial_o), 32'd0);
      checkOutput("break_busy", 32'(busy_o), 32'd1);
    end
    break_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock_i);
      #1;
      cycle++;
      checkOutput("mark_serial", 32'(serial_o), 32'd1);
      checkOutput("mark_busy", 32'(busy_o), 32'd1);
    end
    @(posedge clock_i);
    #1;
    cycle++;
    checkOutput("after_break_busy", 32'(busy_o), 32'd0);
    checkOutput("after_break_serial", 32'(serial_o), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
